dut_method_initiator: RTL and testbench
=======================================

Name: dut_method_initiator

Overview:
- Initiator-side counterpart to the DUT's enable/ready method interface.
- Accepts packet lengths and data words from a host over valid/ready channels, and issues the matching method calls: one len call, then exactly that many din calls.
- Drains the DUT's dout actionvalue method into a registered host-facing output.
- Sits between the testbench host/driver and the DUT inside the wrapper.

Parameters:
- DATA_W, 8, width of din/dout values.
- LEN_W, 8, width of the packet length.
- FIFO_DEPTH, 8, data-word buffer depth (power of 2, ≥2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- host_len_value  input  LEN_W  packet length request.
- host_len_valid  input  1  length request valid.
- host_len_ready  output  1  length accepted this cycle when valid & ready.
- host_din_value  input  DATA_W  data word to send.
- host_din_valid  input  1  data word valid.
- host_din_ready  output  1  data FIFO not full.
- len_value  output  LEN_W  argument of the len method.
- len_en  output  1  len method enable.
- len_rdy  input  1  len method ready.
- din_value  output  DATA_W  argument of the din method.
- din_en  output  1  din method enable.
- din_rdy  input  1  din method ready.
- dout_en  output  1  dout actionvalue enable.
- dout_value  input  DATA_W  dout result.
- dout_rdy  input  1  dout ready.
- host_dout_value  output  DATA_W  captured dout result.
- host_dout_valid  output  1  result held.
- host_dout_ready  input  1  host consumes the result.
- busy  output  1  state != IDLE.
- pkt_count  output  16  completed packets, wraps 0xFFFF->0.

Behaviour:
- Method rule: a method fires in the cycle its en & rdy are both 1.
  - Every *_en is combinational and never 1 while its rdy is 0.
  - *_en is forced 0 while RST_N=0.
- Reset (RST_N=0 at an edge):
  - state=IDLE, FIFO emptied, remaining=0, pkt_count=0, host_dout_valid=0, host_dout_value=0, len_value=0.
  - host_len_ready and host_din_ready are 0 while RST_N=0.
  - Reset mid-packet abandons the packet, drops buffered words, and issues no further calls.
- Data FIFO:
  - Push on host_din_valid & host_din_ready, where host_din_ready = !full.
  - When full, the push is refused even if a pop occurs in the same cycle.
  - Words may be pushed in any state, including ahead of their length.
  - Simultaneous push and pop with the FIFO not full: both take effect and the count is unchanged.
  - A word pushed at edge t is visible on din_value after t.
- FSM:
  - IDLE: host_len_ready=1.
    - On accept with value 0: stay IDLE; no call, pkt_count unchanged.
    - On accept with value L>0: latch len_value=L, remaining=L, go to LEN. len_en is earliest in the next cycle.
  - LEN: len_en=len_rdy. On fire, go to DATA.
  - DATA: din_en = din_rdy & !empty; din_value = FIFO head.
    - On fire: pop, remaining-=1.
    - If remaining was 1: go to IDLE, pkt_count+=1.
    - An empty FIFO stalls, and so does din_rdy=0; no timeout.
- Back-to-back packets: the next length is accepted in the first IDLE cycle, and len_en can follow one cycle later.
- Dout path:
  - dout_en = dout_rdy & (!host_dout_valid | host_dout_ready).
  - On fire, register dout_value into host_dout_value and set host_dout_valid=1.
  - On host_dout_ready with no fire, clear host_dout_valid.
  - Full throughput: one result per cycle when the host is always ready.
  - The dout path is independent of the FSM.

Test Plan:
- Reset: RST_N=0 for 2 cycles, all rdy=1, host valids=1 -> len_en=din_en=dout_en=0, host_*_ready=0, busy=0, pkt_count=0, host_dout_valid=0.
- Basic packet: push 0xA1,0xB2,0xC3; len 3; all rdy=1 -> one len_en cycle with len_value=3, then din_en on 3 consecutive cycles with values A1,B2,C3 -> busy=0, pkt_count=1.
- Backpressure: during DATA drive din_rdy=1,0,0,1,1 -> din_en=din_rdy each cycle, order A1,B2,C3 preserved; len_rdy=0 for 4 cycles holds LEN with len_en=0.
- FIFO full: push 9 words 0x01..0x09 with no length -> host_din_ready=0 after the 8th, word 0x09 held; then len 2 -> 0x01,0x02 sent, ready returns, 0x09 accepted.
- Zero length: len 0 -> no len_en, pkt_count unchanged, host_len_ready=1 next cycle; reset mid-DATA of a len-5 packet after 2 words -> no further din_en, FIFO empty, pkt_count=0.
- Dout: dout_rdy=1, dout_value 0x11 then 0x22, host_dout_ready=0 -> one fire, host_dout_value=0x11 held, dout_en=0; raise host_dout_ready -> 0x22 captured next cycle.

Source files
------------

// File: rtl/dut_method_initiator.sv
// Initiator for an enable/ready method interface: buffers host data words, issues one
// len call followed by that many din calls, and drains dout into a registered host output.
module dut_method_initiator #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [LEN_W-1:0]  host_len_value,
    input  logic              host_len_valid,
    output logic              host_len_ready,
    input  logic [DATA_W-1:0] host_din_value,
    input  logic              host_din_valid,
    output logic              host_din_ready,
    output logic [LEN_W-1:0]  len_value,
    output logic              len_en,
    input  logic              len_rdy,
    output logic [DATA_W-1:0] din_value,
    output logic              din_en,
    input  logic              din_rdy,
    output logic              dout_en,
    input  logic [DATA_W-1:0] dout_value,
    input  logic              dout_rdy,
    output logic [DATA_W-1:0] host_dout_value,
    output logic              host_dout_valid,
    input  logic              host_dout_ready,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    PTR_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  lenValue_q, lenValue_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [15:0]       pktCount_q, pktCount_d;
    logic [AW:0]       wrPtr_q, wrPtr_d;
    logic [AW:0]       rdPtr_q, rdPtr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] hostDoutValue_q, hostDoutValue_d;
    logic              hostDoutValid_q, hostDoutValid_d;
    logic              fifoFull, fifoEmpty, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifoEmpty      = (wrPtr_q == rdPtr_q);
    assign fifoFull       = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                            (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign host_din_ready = RST_N && !fifoFull;
    assign push           = host_din_valid && host_din_ready;
    assign pop            = din_en;
    assign din_value      = mem_q[rdPtr_q[AW-1:0]];
    assign len_value      = lenValue_q;
    assign busy           = (state_q != IDLE);
    assign pkt_count      = pktCount_q;

    always_comb begin
        state_d        = state_q;
        lenValue_d     = lenValue_q;
        remaining_d    = remaining_q;
        pktCount_d     = pktCount_q;
        host_len_ready = 1'b0;
        len_en         = 1'b0;
        din_en         = 1'b0;
        case (state_q)
            IDLE: begin
                host_len_ready = RST_N;
                if (RST_N && host_len_valid && (host_len_value != '0)) begin
                    lenValue_d  = host_len_value;
                    remaining_d = host_len_value;
                    state_d     = LEN;
                end
            end
            LEN: begin
                len_en = RST_N && len_rdy;
                if (len_en) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                din_en = RST_N && din_rdy && !fifoEmpty;
                if (din_en) begin
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d    = IDLE;
                        pktCount_d = pktCount_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
    end

    // The result register may take a new value in the same cycle the host consumes the old one.
    always_comb begin
        dout_en         = RST_N && dout_rdy && (!hostDoutValid_q || host_dout_ready);
        hostDoutValue_d = hostDoutValue_q;
        hostDoutValid_d = hostDoutValid_q;
        if (dout_en) begin
            hostDoutValue_d = dout_value;
            hostDoutValid_d = 1'b1;
        end else if (host_dout_ready) begin
            hostDoutValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q         <= IDLE;
            lenValue_q      <= '0;
            remaining_q     <= '0;
            pktCount_q      <= '0;
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            hostDoutValue_q <= '0;
            hostDoutValid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lenValue_q      <= lenValue_d;
            remaining_q     <= remaining_d;
            pktCount_q      <= pktCount_d;
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            hostDoutValue_q <= hostDoutValue_d;
            hostDoutValid_q <= hostDoutValid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= host_din_value;
        end
    end

    assign host_dout_value = hostDoutValue_q;
    assign host_dout_valid = hostDoutValid_q;

endmodule

// File: tb/tb_dut_method_initiator.sv
// Scoreboard bench for dut_method_initiator: a call-sequence model predicts every method
// call and host-side result; a negedge monitor compares the DUT against it.
module tb_dut_method_initiator;

    localparam int DATA_W     = 8;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 8;

    logic              CLK;
    logic              RST_N;
    logic [LEN_W-1:0]  host_len_value;
    logic              host_len_valid;
    logic              host_len_ready;
    logic [DATA_W-1:0] host_din_value;
    logic              host_din_valid;
    logic              host_din_ready;
    logic [LEN_W-1:0]  len_value;
    logic              len_en;
    logic              len_rdy;
    logic [DATA_W-1:0] din_value;
    logic              din_en;
    logic              din_rdy;
    logic              dout_en;
    logic [DATA_W-1:0] dout_value;
    logic              dout_rdy;
    logic [DATA_W-1:0] host_dout_value;
    logic              host_dout_valid;
    logic              host_dout_ready;
    logic              busy;
    logic [15:0]       pkt_count;

    dut_method_initiator #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .host_len_value(host_len_value), .host_len_valid(host_len_valid),
        .host_len_ready(host_len_ready),
        .host_din_value(host_din_value), .host_din_valid(host_din_valid),
        .host_din_ready(host_din_ready),
        .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
        .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
        .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
        .host_dout_value(host_dout_value), .host_dout_valid(host_dout_valid),
        .host_dout_ready(host_dout_ready),
        .busy(busy), .pkt_count(pkt_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;
    logic regReady = 1'b0;

    // Outstanding calls: a value >= 0 is a len call with that argument, -1 is a din call.
    int          callQ[$];
    logic [7:0]  wordQ[$];
    logic [7:0]  doutQ[$];
    logic [15:0] expPkt = '0;

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge CLK) begin
        int   head;
        logic expLenRdy, expDinRdy, expLenEn, expDinEn, expDoutEn;
        if (regReady) begin
            head      = (callQ.size() != 0) ? callQ[0] : -2;
            expLenRdy = RST_N && (callQ.size() == 0);
            expDinRdy = RST_N && (wordQ.size() < FIFO_DEPTH);
            expLenEn  = RST_N && (head >= 0) && len_rdy;
            expDinEn  = RST_N && (head == -1) && din_rdy && (wordQ.size() != 0);
            expDoutEn = RST_N && dout_rdy && ((doutQ.size() == 0) || host_dout_ready);

            checkOutput("pkt_count", {16'd0, pkt_count}, {16'd0, expPkt});
            checkOutput("busy", {31'd0, busy}, {31'd0, callQ.size() != 0});
            checkOutput("host_dout_valid", {31'd0, host_dout_valid}, {31'd0, doutQ.size() != 0});
            if (doutQ.size() != 0)
                checkOutput("host_dout_value", {24'd0, host_dout_value}, {24'd0, doutQ[0]});
            checkOutput("host_len_ready", {31'd0, host_len_ready}, {31'd0, expLenRdy});
            checkOutput("host_din_ready", {31'd0, host_din_ready}, {31'd0, expDinRdy});
            checkOutput("len_en", {31'd0, len_en}, {31'd0, expLenEn});
            checkOutput("din_en", {31'd0, din_en}, {31'd0, expDinEn});
            checkOutput("dout_en", {31'd0, dout_en}, {31'd0, expDoutEn});
            if (expLenEn)
                checkOutput("len_value", {24'd0, len_value}, head);
            if (expDinEn)
                checkOutput("din_value", {24'd0, din_value}, {24'd0, wordQ[0]});

            if (!RST_N) begin
                callQ.delete();
                wordQ.delete();
                doutQ.delete();
                expPkt = '0;
            end else begin
                if (expLenEn) void'(callQ.pop_front());
                if (expDinEn) begin
                    void'(callQ.pop_front());
                    void'(wordQ.pop_front());
                    if (callQ.size() == 0) expPkt = expPkt + 16'd1;
                end
                if (host_din_valid && expDinRdy) wordQ.push_back(host_din_value);
                if (host_len_valid && expLenRdy && (host_len_value != 0)) begin
                    callQ.push_back(int'(host_len_value));
                    for (int i = 0; i < int'(host_len_value); i++) callQ.push_back(-1);
                end
                if (host_dout_ready && (doutQ.size() != 0)) void'(doutQ.pop_front());
                if (expDoutEn) doutQ.push_back(dout_value);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic lv, input logic [7:0] lval,
                                 input logic dv, input logic [7:0] dval,
                                 input logic lr, input logic dr, input logic dor,
                                 input logic [7:0] dov, input logic hdr);
        RST_N           = rst;
        host_len_valid  = lv;
        host_len_value  = lval;
        host_din_valid  = dv;
        host_din_value  = dval;
        len_rdy         = lr;
        din_rdy         = dr;
        dout_rdy        = dor;
        dout_value      = dov;
        host_dout_ready = hdr;
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] basicWords[3] = '{8'hA1, 8'hB2, 8'hC3};
    logic       dinPattern[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset with every ready and valid asserted.
        applyStimulus(0, 1, 8'd3, 1, 8'h55, 1, 1, 1, 8'h77, 1);
        regReady = 1'b1;
        applyStimulus(0, 1, 8'd3, 1, 8'h55, 1, 1, 1, 8'h77, 1);

        // Basic packet.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, basicWords[i], 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 8'd3, 0, 0, 1, 1, 0, 0, 0);
        repeat (6) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        // Backpressure on len and din.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, basicWords[i], 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 8'd3, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, dinPattern[i], 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        // Fill the FIFO past capacity, then release two words.
        for (int i = 1; i <= 9; i++) applyStimulus(1, 0, 0, 1, 8'(i), 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 1, 8'h09, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 8'd2, 1, 8'h09, 1, 1, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 0, 1, 8'h09, 1, 1, 0, 0, 0);

        // Zero length, then reset in the middle of a len-5 packet.
        applyStimulus(1, 1, 8'd0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 8'd5, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        // Dout holding and release.
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 8'h11, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 8'h22, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 8'h22, 1);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 8'h33, 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(499) != 0),
                          ($urandom_range(3) == 0), 8'($urandom_range(6)),
                          ($urandom_range(1) == 0), 8'($urandom),
                          ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                          ($urandom_range(2) != 0), 8'($urandom),
                          ($urandom_range(2) != 0));
        end

        // Drain any open packet.
        repeat (40) applyStimulus(1, 0, 0, 1, 8'($urandom), 1, 1, 1, 8'($urandom), 1);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
